// File: rtl/sum_accum.sv
// sum_accum: accumulates COUNT adder sums (or fewer, on flush) into an ACC_W-bit
// total and presents total, sample count and overflow flag on a valid/ready port.
//
// Build option: define SUM_ACCUM_SAT_EN to saturate the accumulator at
// 2^ACC_W-1 on overflow; by default it wraps modulo 2^ACC_W. The overflow flag
// is set in both builds, and handshake timing is identical.
module sum_accum #(
  parameter int IN_W  = 5,
  parameter int ACC_W = 8,
  parameter int COUNT = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [IN_W-1:0]            in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       flush,
  output logic [ACC_W-1:0]           out_data,
  output logic [$clog2(COUNT+1)-1:0] out_count,
  output logic                       out_ovf,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int CNT_W = $clog2(COUNT + 1);
  localparam logic [CNT_W-1:0] COUNT_C = CNT_W'(COUNT);
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

`ifdef SUM_ACCUM_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  // live_q keeps in_ready low during reset and until the first clock after release.
  logic             live_q, live_d;

  logic             accept;
  logic             xfer;
  logic [ACC_W:0]   sum_wide;
  logic             carry;
  logic [ACC_W-1:0] acc_add;
  logic [CNT_W-1:0] cnt_inc;

  // Handshake qualifiers: no input bypass while a result is pending.
  assign in_ready  = live_q & (state_q != HOLD);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == HOLD);
  assign xfer      = out_valid & out_ready;

  // Result port shows the held block only; zero otherwise, including in reset.
  assign out_data  = out_valid ? acc_q : '0;
  assign out_count = out_valid ? cnt_q : '0;
  assign out_ovf   = out_valid & ovf_q;

  // Add at ACC_W+1 bits so the carry out exposes a true-sum overflow.
  always_comb begin
    sum_wide = {1'b0, acc_q} + (ACC_W + 1)'(in_data);
    carry    = sum_wide[ACC_W];
    cnt_inc  = cnt_q + 1'b1;
    if (carry && SAT_EN) begin
      acc_add = ACC_MAX;
    end else begin
      acc_add = sum_wide[ACC_W-1:0];
    end
  end

  // Next-state and datapath update for the IDLE/ACCUM/HOLD block sequencer.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    live_d  = 1'b1;

    unique case (state_q)
      IDLE: begin
        // flush without an accept has nothing to close and is ignored here.
        if (accept) begin
          acc_d = ACC_W'(in_data);
          cnt_d = CNT_W'(1);
          ovf_d = 1'b0;
          if ((COUNT == 1) || flush) begin
            state_d = HOLD;
          end else begin
            state_d = ACCUM;
          end
        end
      end

      ACCUM: begin
        if (accept) begin
          acc_d = acc_add;
          cnt_d = cnt_inc;
          ovf_d = ovf_q | carry;
          // A flush in the same cycle closes the block with this sample included.
          if ((cnt_inc == COUNT_C) || flush) begin
            state_d = HOLD;
          end
        end else if (flush) begin
          state_d = HOLD;
        end
      end

      HOLD: begin
        // Result held stable until taken; flush has no effect here.
        if (xfer) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      live_q  <= live_d;
    end
  end

endmodule

// File: tb/tb_sum_accum.sv
// tb_sum_accum: self-checking bench for sum_accum. Instance A uses the default
// parameters and is checked every cycle against a queue-based block model under
// directed and random traffic; instance B (ACC_W=6, COUNT=4) exercises overflow.
module tb_sum_accum;

  localparam int A_MAX   = 255;
  localparam int A_COUNT = 8;
  localparam int B_MAX   = 63;

  logic       clk;
  logic       rst_n;

  logic [4:0] a_in_data;
  logic       a_in_valid, a_in_ready, a_flush;
  logic [7:0] a_out_data;
  logic [3:0] a_out_count;
  logic       a_out_ovf, a_out_valid, a_out_ready;

  logic [4:0] b_in_data;
  logic       b_in_valid, b_in_ready, b_flush;
  logic [5:0] b_out_data;
  logic [2:0] b_out_count;
  logic       b_out_ovf, b_out_valid, b_out_ready;

  int checks = 0;
  int errors = 0;

  // Reference model state for instance A: samples of the open block and the
  // pending result, if any.
  int q[$];
  bit pend;
  int pend_data;
  int pend_cnt;
  bit pend_ovf;
  bit ready_ok;

  sum_accum dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (a_in_data),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .flush     (a_flush),
    .out_data  (a_out_data),
    .out_count (a_out_count),
    .out_ovf   (a_out_ovf),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready)
  );

  sum_accum #(.IN_W(5), .ACC_W(6), .COUNT(4)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (b_in_data),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .flush     (b_flush),
    .out_data  (b_out_data),
    .out_count (b_out_count),
    .out_ovf   (b_out_ovf),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Block result from the true unsigned total.
  function automatic int block_result(input int total, input int maxv);
`ifdef SUM_ACCUM_SAT_EN
    return (total > maxv) ? maxv : total;
`else
    return total % (maxv + 1);
`endif
  endfunction

  function automatic void close_block();
    int total = 0;
    foreach (q[i]) total += q[i];
    pend_cnt  = q.size();
    pend_ovf  = (total > A_MAX);
    pend_data = block_result(total, A_MAX);
    pend      = 1'b1;
    q.delete();
  endfunction

  // Apply one clock edge to the model using the inputs present at that edge.
  function automatic void model_step();
    if (pend) begin
      if (a_out_ready) pend = 1'b0;
    end else if (ready_ok) begin
      if (a_in_valid) q.push_back(int'(a_in_data));
      if ((q.size() > 0) && ((q.size() == A_COUNT) || a_flush)) close_block();
    end
    ready_ok = 1'b1;
  endfunction

  function automatic void model_reset();
    q.delete();
    pend     = 1'b0;
    ready_ok = 1'b0;
  endfunction

  task automatic check_a(input string tag);
    check({tag, "_in_ready"}, a_in_ready, ready_ok && !pend);
    check({tag, "_out_valid"}, a_out_valid, pend);
    if (pend) begin
      check({tag, "_out_data"}, a_out_data, pend_data);
      check({tag, "_out_count"}, a_out_count, pend_cnt);
      check({tag, "_out_ovf"}, a_out_ovf, pend_ovf);
    end
  endtask

  // Called at a negedge: drive A, clock it, then check A at the next negedge.
  task automatic cycle(input bit v, input int d, input bit f, input bit r);
    a_in_valid  = v;
    a_in_data   = 5'(d);
    a_flush     = f;
    a_out_ready = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_a("a");
  endtask

  task automatic b_push(input int d);
    b_in_valid = 1'b1;
    b_in_data  = 5'(d);
    check("b_in_ready", b_in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    b_in_valid = 1'b0;
  endtask

  task automatic b_block(input int s0, input int s1, input int s2, input int s3);
    int total;
    total = s0 + s1 + s2 + s3;
    b_push(s0);
    b_push(s1);
    b_push(s2);
    b_push(s3);
    check("b_out_valid", b_out_valid, 1);
    check("b_out_data", b_out_data, block_result(total, B_MAX));
    check("b_out_count", b_out_count, 4);
    check("b_out_ovf", b_out_ovf, total > B_MAX);
    check("b_in_ready_hold", b_in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    check("b_out_valid_after", b_out_valid, 0);
  endtask

  initial begin
    rst_n       = 1'b0;
    a_in_valid  = 1'b0;
    a_in_data   = '0;
    a_flush     = 1'b0;
    a_out_ready = 1'b0;
    b_in_valid  = 1'b0;
    b_in_data   = '0;
    b_flush     = 1'b0;
    b_out_ready = 1'b1;
    model_reset();

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_in_ready", a_in_ready, 0);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_data", a_out_data, 0);
    check("rst_out_count", a_out_count, 0);
    check("rst_out_ovf", a_out_ovf, 0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready_before_clk", a_in_ready, 0);
    cycle(0, 0, 0, 1);
    check("rel_in_ready_after_clk", a_in_ready, 1);

    // 1..8 back-to-back: one result cycle, in_ready low for that cycle only.
    for (int i = 1; i <= 8; i++) cycle(1, i, 0, 1);
    check("t1_out_valid", a_out_valid, 1);
    check("t1_out_data", a_out_data, 36);
    check("t1_out_count", a_out_count, 8);
    check("t1_out_ovf", a_out_ovf, 0);
    check("t1_in_ready", a_in_ready, 0);
    cycle(0, 0, 0, 1);
    check("t1_out_valid_drop", a_out_valid, 0);
    check("t1_in_ready_back", a_in_ready, 1);

    // Maximum in-range total.
    for (int i = 0; i < 8; i++) cycle(1, 31, 0, 1);
    check("t2_out_data", a_out_data, 248);
    check("t2_out_ovf", a_out_ovf, 0);
    cycle(0, 0, 0, 1);

    // flush in IDLE is ignored.
    cycle(0, 0, 1, 1);
    check("t4_idle_flush", a_out_valid, 0);

    // flush with no accept closes a partial block.
    cycle(1, 10, 0, 1);
    cycle(1, 20, 0, 1);
    cycle(0, 0, 1, 1);
    check("t4a_out_data", a_out_data, 30);
    check("t4a_out_count", a_out_count, 2);
    cycle(0, 0, 0, 1);

    // flush with an accept includes that sample.
    cycle(1, 10, 0, 1);
    cycle(1, 20, 0, 1);
    cycle(1, 5, 1, 1);
    check("t4b_out_data", a_out_data, 35);
    check("t4b_out_count", a_out_count, 3);
    cycle(0, 0, 0, 1);

    // Stall in HOLD for 5 cycles; flush in HOLD ignored.
    for (int i = 0; i < 8; i++) cycle(1, i + 3, 0, 0);
    for (int i = 0; i < 5; i++) begin
      check("t5_hold_valid", a_out_valid, 1);
      check("t5_hold_data", a_out_data, 52);
      check("t5_hold_in_ready", a_in_ready, 0);
      cycle(1, 7, (i == 2), 0);
    end
    cycle(0, 0, 0, 1);
    check("t5_idle_after", a_out_valid, 0);

    // Asynchronous reset mid-block discards the partial block.
    for (int i = 0; i < 3; i++) cycle(1, 9, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("t6_rst_in_ready", a_in_ready, 0);
    check("t6_rst_out_valid", a_out_valid, 0);
    check("t6_rst_out_data", a_out_data, 0);
    check("t6_rst_out_count", a_out_count, 0);
    check("t6_rst_out_ovf", a_out_ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) cycle(1, 1, 0, 1);
    check("t6_out_data", a_out_data, 8);
    check("t6_out_count", a_out_count, 8);
    cycle(0, 0, 0, 1);

    // Overflow on the narrow instance (wrap or saturate depending on build).
    b_block(31, 31, 31, 31);
    b_block(1, 2, 3, 4);
    b_block(31, 31, 1, 0);
    b_block(31, 31, 2, 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 31),
            $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
